// File: rtl/channel_scan_seq.sv
// Channel scan sequencer: steps 3-bit decoder select through the enabled mask bits, dwell_q+1 cycles each.
// Latency: outputs registered, one edge after the sampled input. Backpressure: none; stop aborts, start is ignored while busy.
module channel_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // Lowest set bit; callers only use it when m != 0.
    function automatic logic [2:0] first_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above s.
    function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(s))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] nxt;
    assign nxt = next_ch(mask_q, sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (mask != 8'd0) begin
                        mask_d  = mask;
                        dwell_d = dwell;
                        sel_d   = first_ch(mask);
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (stop) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q < dwell_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (nxt[3]) begin
                    sel_d = nxt[2:0];
                    cnt_d = '0;
                end else if (mode_cont && (mask != 8'd0)) begin
                    // Continuous pass restarts with freshly sampled mask/dwell.
                    mask_d  = mask;
                    dwell_d = dwell;
                    sel_d   = first_ch(mask);
                    cnt_d   = '0;
                    wrap_d  = 1'b1;
                end else begin
                    if (mode_cont) begin
                        mask_d  = mask;
                        dwell_d = dwell;
                    end
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= 8'd0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_channel_scan_seq.sv
// Directed bench for channel_scan_seq: vector table plus hand-written max-dwell and async-reset sequences.
module tb_channel_scan_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;
    logic       wrap;

    int tests;
    int fails;

    channel_scan_seq #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .mask      (mask),
        .dwell     (dwell),
        .sel       (sel),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       mode_cont;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic mc,
                                input logic [7:0] m, input logic [7:0] d,
                                input logic [2:0] s, input logic e, input logic b,
                                input logic dn, input logic w);
        vec_t v;
        v = '{st, sp, mc, m, d, s, e, b, dn, w};
        return v;
    endfunction

    // Compares {sel,en,busy,done,wrap}.
    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {sel, en, busy, done, wrap};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got sel=%0d en=%b busy=%b done=%b wrap=%b, expected sel=%0d en=%b busy=%b done=%b wrap=%b",
                     name, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic mc,
                         input logic [7:0] m, input logic [7:0] d);
        start     = st;
        stop      = sp;
        mode_cont = mc;
        mask      = m;
        dwell     = d;
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        drive(0, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        check("reset_state", 7'b000_0000);
        #12;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 7'b000_0000);

        // Single pass A5/dwell 2; mask/dwell changes mid-pass must be ignored.
        vecs.push_back(mk(1,0,0,8'hA5,8'd2, 3'd0,1,1,0,0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0,0,0,8'hFF,8'd0, 3'd0,1,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,8'hFF,8'd0, 3'd2,1,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,8'hFF,8'd0, 3'd5,1,1,0,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd7,1,1,0,0));
        vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd7,0,0,1,0));
        vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd7,0,0,0,0));
        // Empty scan, stop alone in IDLE, start+stop in IDLE.
        vecs.push_back(mk(1,0,0,8'h00,8'd2, 3'd7,0,0,1,0));
        vecs.push_back(mk(0,0,0,8'h00,8'd2, 3'd7,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'hA5,8'd2, 3'd7,0,0,0,0));
        vecs.push_back(mk(1,1,0,8'hA5,8'd2, 3'd7,0,0,0,0));
        // Ignored start at sel=0, then abort at sel=2.
        vecs.push_back(mk(1,0,0,8'hA5,8'd2, 3'd0,1,1,0,0));
        vecs.push_back(mk(1,0,0,8'hA5,8'd2, 3'd0,1,1,0,0));
        vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd0,1,1,0,0));
        vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd2,1,1,0,0));
        vecs.push_back(mk(0,1,0,8'hA5,8'd2, 3'd2,0,0,0,0));
        vecs.push_back(mk(0,0,0,8'hA5,8'd2, 3'd2,0,0,0,0));
        // Continuous 81/dwell 0, then drop mode_cont while sel=0.
        vecs.push_back(mk(1,0,1,8'h81,8'd0, 3'd0,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h81,8'd0, 3'd7,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h81,8'd0, 3'd0,1,1,0,1));
        vecs.push_back(mk(0,0,1,8'h81,8'd0, 3'd7,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h81,8'd0, 3'd0,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h81,8'd0, 3'd7,1,1,0,0));
        vecs.push_back(mk(0,0,0,8'h81,8'd0, 3'd7,0,0,1,0));
        vecs.push_back(mk(0,0,0,8'h81,8'd0, 3'd7,0,0,0,0));
        // Wrap reloads new mask/dwell; a wrap onto an empty mask finishes instead.
        vecs.push_back(mk(1,0,1,8'h01,8'd1, 3'd0,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h04,8'd0, 3'd0,1,1,0,0));
        vecs.push_back(mk(0,0,1,8'h04,8'd0, 3'd2,1,1,0,1));
        vecs.push_back(mk(0,0,1,8'h04,8'd0, 3'd2,1,1,0,1));
        vecs.push_back(mk(0,0,1,8'h00,8'd0, 3'd2,0,0,1,0));
        vecs.push_back(mk(0,0,0,8'h00,8'd0, 3'd2,0,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].mode_cont, vecs[i].mask, vecs[i].dwell);
            step();
            check($sformatf("vec%0d", i),
                  {vecs[i].sel, vecs[i].en, vecs[i].busy, vecs[i].done, vecs[i].wrap});
        end

        // Maximum dwell: one channel held for 256 cycles.
        drive(1, 0, 0, 8'h80, 8'hFF);
        step();
        drive(0, 0, 0, 8'h80, 8'hFF);
        check("maxdwell_start", 7'b111_1100);
        n = 0;
        while (en === 1'b1 && n < 400) begin
            if (sel !== 3'd7) begin
                check("maxdwell_sel", 7'b111_1100);
            end
            n++;
            step();
        end
        check_int("maxdwell_cycles", n, 256);
        check("maxdwell_done", 7'b111_0010);
        step();
        check("maxdwell_idle", 7'b111_0000);

        // Asynchronous reset mid-scan at sel=5.
        drive(1, 0, 0, 8'hA5, 8'd0);
        step();
        drive(0, 0, 0, 8'hA5, 8'd0);
        check("rst_scan_sel0", 7'b000_1100);
        step();
        check("rst_scan_sel2", 7'b010_1100);
        step();
        check("rst_scan_sel5", 7'b101_1100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 7'b000_0000);
        step();
        step();
        check("rst_held", 7'b000_0000);
        rst_n = 1'b1;
        drive(1, 0, 0, 8'h02, 8'd0);
        step();
        drive(0, 0, 0, 8'h02, 8'd0);
        check("post_rst_start", 7'b001_1100);
        step();
        check("post_rst_done", 7'b001_0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
